// File: rtl/high_addr_run_monitor.sv
// high_addr_run_monitor: measures consecutive high_addr cycles and raises a sticky irq at THRESHOLD.
// Define HIGH_ADDR_ALARM_COUNT_EN to add the saturating alarm_count output.
module high_addr_run_monitor #(
   parameter int CNT_W     = 8,
   parameter int THRESHOLD = 16
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             high_addr,
   input  logic             irq_ack,
   output logic             irq,
   output logic [CNT_W-1:0] run_len,
   output logic             busy
`ifdef HIGH_ADDR_ALARM_COUNT_EN
   ,
   output logic [CNT_W-1:0] alarm_count
`endif
);
   typedef enum logic [1:0] {IDLE, COUNT, ALARM, WAIT_LOW} state_t;
   localparam logic [CNT_W-1:0] MAX_CNT = '1;
   localparam logic [CNT_W:0]   THR     = (CNT_W+1)'(THRESHOLD);
   generate
      if (THRESHOLD < 1 || THRESHOLD > (2**CNT_W) - 1) begin : g_bad_threshold
         $error("high_addr_run_monitor: THRESHOLD out of range 1 .. 2**CNT_W-1");
      end
   endgenerate
   state_t           r_state;
   state_t           w_next;
   logic             r_irq;
   logic             r_busy;
   logic [CNT_W-1:0] r_run_len;
   logic [CNT_W:0]   w_run_inc;
   logic [CNT_W-1:0] w_run_next;
   // one extra bit so run_len+1 cannot wrap before the threshold compare
   assign w_run_inc  = {1'b0, r_run_len} + 1'b1;
   assign w_run_next = high_addr ? ((r_run_len == MAX_CNT) ? r_run_len : w_run_inc[CNT_W-1:0]) : '0;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (high_addr) w_next = (THRESHOLD == 1) ? ALARM : COUNT;
         COUNT:    w_next = !high_addr ? IDLE : (w_run_inc >= THR) ? ALARM : COUNT;
         ALARM:    if (irq_ack) w_next = high_addr ? WAIT_LOW : IDLE;
         WAIT_LOW: if (!high_addr) w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state   <= IDLE;
         r_irq     <= 1'b0;
         r_busy    <= 1'b0;
         r_run_len <= '0;
      end else begin
         r_state   <= w_next;
         r_irq     <= (w_next == ALARM);
         r_busy    <= (w_next != IDLE);
         r_run_len <= w_run_next;
      end
   end
   assign irq     = r_irq;
   assign busy    = r_busy;
   assign run_len = r_run_len;
`ifdef HIGH_ADDR_ALARM_COUNT_EN
   logic [CNT_W-1:0] r_alarm_count;
   logic             w_alarm_entry;
   assign w_alarm_entry = (w_next == ALARM) && (r_state != ALARM);
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) r_alarm_count <= '0;
      else if (w_alarm_entry && r_alarm_count != MAX_CNT) r_alarm_count <= r_alarm_count + 1'b1;
   end
   assign alarm_count = r_alarm_count;
`endif
endmodule

// File: tb/tb_high_addr_run_monitor.sv
// tb_high_addr_run_monitor: scoreboard bench comparing the monitor against a run/alarm reference model.
module tb_high_addr_run_monitor;
   localparam int CNT_W = 8;
   localparam int TH    = 4;
   localparam int MAXV  = (1 << CNT_W) - 1;
   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic high_addr = 1'b0;
   logic irq_ack = 1'b0;
   logic irq, busy;
   logic [CNT_W-1:0] run_len;
`ifdef HIGH_ADDR_ALARM_COUNT_EN
   logic [CNT_W-1:0] alarm_count;
`endif
   high_addr_run_monitor #(.CNT_W(CNT_W), .THRESHOLD(TH)) dut (
      .clk(clk), .rstN(rstN), .high_addr(high_addr), .irq_ack(irq_ack),
      .irq(irq), .run_len(run_len), .busy(busy)
`ifdef HIGH_ADDR_ALARM_COUNT_EN
      , .alarm_count(alarm_count)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {logic e_irq; logic e_busy; int e_run; int e_ac;} exp_t;
   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int m_run = 0;
   int m_ac = 0;
   bit m_irq = 0;
   bit m_sup = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_run = 0; m_ac = 0; m_irq = 0; m_sup = 0;
   endtask
   // reference: run length, pending alarm, and "already alarmed this run" suppression
   task automatic step(input bit h, input bit a);
      int nr;
      exp_t e;
      @(negedge clk);
      high_addr = h;
      irq_ack = a;
      nr = h ? ((m_run + 1 > MAXV) ? MAXV : m_run + 1) : 0;
      if (m_irq) begin
         if (a) begin m_irq = 0; m_sup = h; end
      end else if (m_sup) begin
         if (!h) m_sup = 0;
      end else if (h && nr >= TH) begin
         m_irq = 1;
         if (m_ac < MAXV) m_ac++;
      end
      m_run = nr;
      e.e_irq = m_irq;
      e.e_busy = m_irq | m_sup | (m_run > 0);
      e.e_run = m_run;
      e.e_ac = m_ac;
      q.push_back(e);
   endtask
   task automatic steps(input int n, input bit h, input bit a);
      for (int i = 0; i < n; i++) step(h, a);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("irq", 32'(irq), 32'(e.e_irq));
            chk("busy", 32'(busy), 32'(e.e_busy));
            chk("run_len", 32'(run_len), e.e_run);
`ifdef HIGH_ADDR_ALARM_COUNT_EN
            chk("alarm_count", 32'(alarm_count), e.e_ac);
`endif
         end
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got 1 expected 0");
      $fatal(1, "timeout");
   end
   initial begin
      #3;
      chk("reset_irq", 32'(irq), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_run_len", 32'(run_len), 0);
      @(negedge clk);
      rstN = 1'b1;
      steps(3, 1, 0); step(0, 0);
      steps(4, 1, 0); steps(10, 0, 0); step(0, 1); step(0, 0);
      steps(4, 1, 0); step(1, 1); steps(20, 1, 0); step(0, 0);
      steps(4, 1, 0); step(1, 1); step(0, 0);
      steps(300, 1, 0); step(1, 1); step(0, 0);
      step(1, 1); step(0, 1); steps(2, 0, 0);
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 99) < 80, $urandom_range(0, 9) == 0);
      step(0, 1); step(0, 0);
      steps(5, 1, 0);
      @(posedge clk);
      #2;
      rstN = 1'b0;
      #1;
      chk("async_reset_irq", 32'(irq), 0);
      chk("async_reset_busy", 32'(busy), 0);
      chk("async_reset_run_len", 32'(run_len), 0);
      q.delete();
      model_reset();
      @(negedge clk);
      high_addr = 1'b0;
      irq_ack = 1'b0;
      rstN = 1'b1;
      steps(2, 0, 0);
      steps(4, 1, 0); step(1, 1); step(0, 0);
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
